// File: rtl/mult_pkg.sv
// Shared definitions for the bus-attached multiplier and its host controller:
// host FSM state encoding and the multiplier bus function codes.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    WAIT_RDY,
    READ_LO,
    READ_HI,
    DONE
  } host_state_t;

  localparam logic [1:0] FUNC_LOAD_M  = 2'b00;
  localparam logic [1:0] FUNC_LOAD_Q  = 2'b01;
  localparam logic [1:0] FUNC_READ_LO = 2'b10;
  localparam logic [1:0] FUNC_READ_HI = 2'b11;

endpackage

// File: rtl/bus_tristate.sv
// Registered tristate driver for the shared multiplier data bus.
// The data inout is assigned only here; sample exposes the resolved bus value.
module bus_tristate #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         drive,
  input  logic [n-1:0] value,
  inout  logic [n-1:0] data,
  output logic [n-1:0] sample
);

  logic         drive_q;
  logic [n-1:0] value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drive_q <= 1'b0;
      value_q <= '0;
    end else begin
      drive_q <= drive;
      value_q <= value;
    end
  end

  assign data   = drive_q ? value_q : {n{1'bz}};
  assign sample = data;

endmodule

// File: rtl/mult_bus_host.sv
// Host controller that runs a full multiply transaction over the multiplier's
// tristate bus. Optional WAIT_RDY timeout enabled by MULT_BUS_HOST_TIMEOUT_EN.
module mult_bus_host
  import mult_pkg::*;
#(
  parameter int n       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] product,
  output logic           err,
  output logic [1:0]     func,
  output logic           oe,
  input  logic           ready,
  inout  logic [n-1:0]   data
);

  host_state_t  state;
  host_state_t  next_state;
  logic [n-1:0] b_q;
  logic [n-1:0] bus_val;
  logic         accept;
  logic         timed_out;

  logic [1:0]   func_next;
  logic         oe_next;
  logic         drive_next;
  logic [n-1:0] bus_next;

  assign accept = (state == IDLE) && start;

`ifdef MULT_BUS_HOST_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;

  assign timed_out = (state == WAIT_RDY) && !ready && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        err <= 1'b0;
      end else if (timed_out) begin
        err <= 1'b1;
      end
      wait_cnt <= (state == WAIT_RDY) ? wait_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timed_out      = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = LOAD_M;
      LOAD_M:   next_state = LOAD_Q;
      LOAD_Q:   next_state = WAIT_RDY;
      WAIT_RDY: begin
        if (ready) begin
          next_state = READ_LO;
        end else if (timed_out) begin
          next_state = DONE;
        end
      end
      READ_LO:  next_state = READ_HI;
      READ_HI:  next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so the
  // multiplier sees stable codes for the whole cycle. The multiplicand goes
  // straight from the a input into the bus output register on the accepting
  // edge, so only b needs its own holding register.
  always_comb begin
    func_next  = FUNC_READ_LO;
    oe_next    = 1'b0;
    drive_next = 1'b0;
    bus_next   = '0;
    case (next_state)
      LOAD_M: begin
        func_next  = FUNC_LOAD_M;
        drive_next = 1'b1;
        bus_next   = a;
      end
      LOAD_Q: begin
        func_next  = FUNC_LOAD_Q;
        drive_next = 1'b1;
        bus_next   = b_q;
      end
      READ_LO: begin
        func_next = FUNC_READ_LO;
        oe_next   = 1'b1;
      end
      READ_HI: begin
        func_next = FUNC_READ_HI;
        oe_next   = 1'b1;
      end
      default: begin
        func_next = FUNC_READ_LO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      b_q     <= '0;
      func    <= FUNC_READ_LO;
      oe      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state <= next_state;
      func  <= func_next;
      oe    <= oe_next;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      if (accept) begin
        b_q <= b;
      end
      if (state == READ_LO) begin
        product[n-1:0] <= bus_val;
      end
      if (state == READ_HI) begin
        product[2*n-1:n] <= bus_val;
      end
      if (timed_out) begin
        product <= '0;
      end
    end
  end

  bus_tristate #(.n(n)) u_bus (
    .clk    (clk),
    .reset  (reset),
    .drive  (drive_next),
    .value  (bus_next),
    .data   (data),
    .sample (bus_val)
  );

endmodule
